// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core: opcodes, FSM states, error codes
// and tape write operations.
package bf_pkg;

    localparam logic [3:0] OP_INC   = 4'h0;
    localparam logic [3:0] OP_DEC   = 4'h1;
    localparam logic [3:0] OP_RIGHT = 4'h2;
    localparam logic [3:0] OP_LEFT  = 4'h3;
    localparam logic [3:0] OP_OPEN  = 4'h4;
    localparam logic [3:0] OP_CLOSE = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OPEN  = 2'd1;
    localparam logic [1:0] ERR_CLOSE = 2'd2;
    localparam logic [1:0] ERR_NEST  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_EXEC     = 4'd2,
        ST_SCAN_F   = 4'd3,
        ST_SCAN_B   = 4'd4,
        ST_WAIT_IN  = 4'd5,
        ST_WAIT_OUT = 4'd6,
        ST_HALT     = 4'd7,
        ST_ERROR    = 4'd8
    } bf_state_e;

    typedef enum logic [1:0] {
        TAPE_NONE = 2'd0,
        TAPE_INC  = 2'd1,
        TAPE_DEC  = 2'd2,
        TAPE_LOAD = 2'd3
    } tape_op_e;

    function automatic logic is_busy(input bf_state_e s);
        return !((s == ST_IDLE) || (s == ST_HALT) || (s == ST_ERROR));
    endfunction

endpackage

// File: rtl/bf_tape.sv
// Data tape: register array with synchronous clear, combinational read at dp.
// Macro BF_SATURATE_EN makes '+'/'-' saturate instead of wrapping.
module bf_tape
    import bf_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TAPE_DEPTH = 256,
    parameter int DP_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DP_W-1:0]   dp,
    input  tape_op_e          op,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] cells_r [TAPE_DEPTH];
    logic [DATA_W-1:0] next_s;

    assign rd_data = cells_r[dp];

    // New value of the addressed cell for the requested operation
    always_comb begin
        next_s = rd_data;
        case (op)
            TAPE_INC: begin
`ifdef BF_SATURATE_EN
                if (rd_data == {DATA_W{1'b1}}) next_s = rd_data;
                else                           next_s = rd_data + DATA_W'(1);
`else
                next_s = rd_data + DATA_W'(1);
`endif
            end
            TAPE_DEC: begin
`ifdef BF_SATURATE_EN
                if (rd_data == {DATA_W{1'b0}}) next_s = rd_data;
                else                           next_s = rd_data - DATA_W'(1);
`else
                next_s = rd_data - DATA_W'(1);
`endif
            end
            TAPE_LOAD: next_s = wr_data;
            default:   next_s = rd_data;
        endcase
    end

    // Cell storage with synchronous active-low clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < TAPE_DEPTH; i++) cells_r[i] <= {DATA_W{1'b0}};
        end else if (op != TAPE_NONE) begin
            cells_r[dp] <= next_s;
        end
    end

endmodule

// File: rtl/bf_core_p.sv
// Sequenced Brainfuck execution core: opcode fetch from external program
// memory, bracket matching by nesting-counter scan. Optional macro: BF_SATURATE_EN.
module bf_core_p
    import bf_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TAPE_DEPTH = 256,
    parameter int PC_W       = 16,
    parameter int NEST_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-1:0]   pm_addr,
    input  logic [3:0]        pm_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              halted,
    output logic [1:0]        error
);

    localparam int DP_W = $clog2(TAPE_DEPTH);

    bf_state_e         state_r, state_nxt_s;
    logic [PC_W-1:0]   pc_r, pc_nxt_s;
    logic [DP_W-1:0]   dp_r, dp_nxt_s;
    logic [NEST_W-1:0] nest_r, nest_nxt_s;
    logic              phase_r, phase_nxt_s;
    logic [1:0]        err_r, err_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic [DATA_W-1:0] out_data_r, out_data_nxt_s;
    logic              in_ready_r, in_ready_nxt_s;
    logic              halted_r, halted_nxt_s;
    logic              busy_r, busy_nxt_s;
    tape_op_e          tape_op_s;
    logic [DATA_W-1:0] cell_s;
    logic              adv_s, step_s;
    logic              pc_last_s, pc_first_s, cell_zero_s, nest_full_s;

    bf_tape #(.DATA_W(DATA_W), .TAPE_DEPTH(TAPE_DEPTH), .DP_W(DP_W)) u_tape (
        .clock   (clock),
        .reset   (reset),
        .dp      (dp_r),
        .op      (tape_op_s),
        .wr_data (in_data),
        .rd_data (cell_s)
    );

    assign pc_last_s   = (pc_r == {PC_W{1'b1}});
    assign pc_first_s  = (pc_r == {PC_W{1'b0}});
    assign cell_zero_s = (cell_s == {DATA_W{1'b0}});
    assign nest_full_s = &nest_r;

    // pc is the registered fetch address; memory data returns during EXEC / scan decode
    assign pm_addr   = pc_r;
    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign halted    = halted_r;
    assign error     = err_r;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= PC_W'(0);
            dp_r        <= DP_W'(0);
            nest_r      <= NEST_W'(0);
            phase_r     <= 1'b0;
            err_r       <= ERR_NONE;
            out_valid_r <= 1'b0;
            out_data_r  <= DATA_W'(0);
            in_ready_r  <= 1'b0;
            halted_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            dp_r        <= dp_nxt_s;
            nest_r      <= nest_nxt_s;
            phase_r     <= phase_nxt_s;
            err_r       <= err_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            halted_r    <= halted_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Next-state logic: decode, scan stepping, pc/dp/nest updates and error detection
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        dp_nxt_s    = dp_r;
        nest_nxt_s  = nest_r;
        phase_nxt_s = 1'b0;
        err_nxt_s   = err_r;
        tape_op_s   = TAPE_NONE;
        adv_s       = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = PC_W'(0);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                case (pm_data)
                    OP_INC:   begin tape_op_s = TAPE_INC; adv_s = 1'b1; end
                    OP_DEC:   begin tape_op_s = TAPE_DEC; adv_s = 1'b1; end
                    OP_RIGHT: begin dp_nxt_s = dp_r + DP_W'(1); adv_s = 1'b1; end
                    OP_LEFT:  begin dp_nxt_s = dp_r - DP_W'(1); adv_s = 1'b1; end
                    OP_OPEN: begin
                        if (!cell_zero_s) begin
                            adv_s = 1'b1;
                        end else if (pc_last_s) begin
                            state_nxt_s = ST_ERROR;
                            err_nxt_s   = ERR_OPEN;
                        end else begin
                            nest_nxt_s  = NEST_W'(1);
                            pc_nxt_s    = pc_r + PC_W'(1);
                            state_nxt_s = ST_SCAN_F;
                        end
                    end
                    OP_CLOSE: begin
                        if (cell_zero_s) begin
                            adv_s = 1'b1;
                        end else if (pc_first_s) begin
                            state_nxt_s = ST_ERROR;
                            err_nxt_s   = ERR_CLOSE;
                        end else begin
                            nest_nxt_s  = NEST_W'(1);
                            pc_nxt_s    = pc_r - PC_W'(1);
                            state_nxt_s = ST_SCAN_B;
                        end
                    end
                    OP_OUT:  state_nxt_s = ST_WAIT_OUT;
                    OP_IN:   state_nxt_s = ST_WAIT_IN;
                    OP_HALT: state_nxt_s = ST_HALT;
                    default: adv_s = 1'b1;
                endcase
            end
            ST_SCAN_F, ST_SCAN_B: begin
                if (!phase_r) begin
                    phase_nxt_s = 1'b1;
                end else begin
                    // "same" bracket deepens nesting, the opposite one closes a level
                    case (pm_data)
                        OP_OPEN, OP_CLOSE: begin
                            if ((pm_data == OP_OPEN) == (state_r == ST_SCAN_F)) begin
                                if (nest_full_s) begin
                                    state_nxt_s = ST_ERROR;
                                    err_nxt_s   = ERR_NEST;
                                end else begin
                                    nest_nxt_s = nest_r + NEST_W'(1);
                                    step_s     = 1'b1;
                                end
                            end else if (nest_r == NEST_W'(1)) begin
                                nest_nxt_s = NEST_W'(0);
                                adv_s      = 1'b1;
                            end else begin
                                nest_nxt_s = nest_r - NEST_W'(1);
                                step_s     = 1'b1;
                            end
                        end
                        OP_HALT: begin
                            if (state_r == ST_SCAN_F) begin
                                state_nxt_s = ST_ERROR;
                                err_nxt_s   = ERR_OPEN;
                            end else begin
                                step_s = 1'b1;
                            end
                        end
                        default: step_s = 1'b1;
                    endcase
                end
            end
            ST_WAIT_OUT: begin
                if (out_valid_r && out_ready) adv_s = 1'b1;
                else                          adv_s = 1'b0;
            end
            ST_WAIT_IN: begin
                if (in_valid && in_ready_r) begin
                    tape_op_s = TAPE_LOAD;
                    adv_s     = 1'b1;
                end else begin
                    adv_s = 1'b0;
                end
            end
            ST_HALT:  state_nxt_s = ST_HALT;
            ST_ERROR: state_nxt_s = ST_ERROR;
            default:  state_nxt_s = ST_IDLE;
        endcase

        if (adv_s) begin
            if (pc_last_s) begin
                state_nxt_s = ST_ERROR;
                err_nxt_s   = ERR_OPEN;
            end else begin
                pc_nxt_s    = pc_r + PC_W'(1);
                state_nxt_s = ST_FETCH;
            end
        end else if (step_s) begin
            if (state_r == ST_SCAN_F) begin
                if (pc_last_s) begin
                    state_nxt_s = ST_ERROR;
                    err_nxt_s   = ERR_OPEN;
                end else begin
                    pc_nxt_s = pc_r + PC_W'(1);
                end
            end else begin
                if (pc_first_s) begin
                    state_nxt_s = ST_ERROR;
                    err_nxt_s   = ERR_CLOSE;
                end else begin
                    pc_nxt_s = pc_r - PC_W'(1);
                end
            end
        end else begin
            pc_nxt_s = pc_nxt_s;
        end
    end

    // Next values of the registered handshake and status outputs
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        in_ready_nxt_s  = in_ready_r;
        halted_nxt_s    = halted_r;
        busy_nxt_s      = is_busy(state_nxt_s);
        case (state_r)
            ST_EXEC: begin
                if (pm_data == OP_OUT) begin
                    out_valid_nxt_s = 1'b1;
                    out_data_nxt_s  = cell_s;
                end else if (pm_data == OP_IN) begin
                    in_ready_nxt_s = 1'b1;
                end else if (pm_data == OP_HALT) begin
                    halted_nxt_s = 1'b1;
                end else begin
                    halted_nxt_s = halted_r;
                end
            end
            ST_WAIT_OUT: begin
                if (out_ready) out_valid_nxt_s = 1'b0;
                else           out_valid_nxt_s = out_valid_r;
            end
            ST_WAIT_IN: begin
                if (in_valid) in_ready_nxt_s = 1'b0;
                else          in_ready_nxt_s = in_ready_r;
            end
            default: halted_nxt_s = halted_r;
        endcase
    end

endmodule

// File: tb/tb_bf_core_p.sv
// Self-checking bench for bf_core_p: program ROM model, scoreboard of
// expected output characters, status and handshake checks.
module tb_bf_core_p;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pm_addr;
    logic [3:0]  pm_data = 4'h0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        halted;
    logic [1:0]  error;

    logic [3:0]  prog [256];
    logic [7:0]  exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_extra = 0;

    bf_core_p u_dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pm_addr   (pm_addr),
        .pm_data   (pm_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .halted    (halted),
        .error     (error)
    );

    always #5 clock = ~clock;

    // Program memory with one cycle read latency
    always @(posedge clock) pm_data <= prog[pm_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each accepted output character with the oldest expectation
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() > 0) chk("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            else                  n_extra++;
        end
    end

    task automatic load_prog(input string p);
        for (int i = 0; i < 256; i++) prog[i] = 4'hF;
        for (int i = 0; i < p.len(); i++) begin
            case (p[i])
                "+": prog[i] = 4'h0;
                "-": prog[i] = 4'h1;
                ">": prog[i] = 4'h2;
                "<": prog[i] = 4'h3;
                "[": prog[i] = 4'h4;
                "]": prog[i] = 4'h5;
                ".": prog[i] = 4'h6;
                ",": prog[i] = 4'h7;
                "N": prog[i] = 4'h8;
                default: prog[i] = 4'hF;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        n_extra = 0;
    endtask

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clock);
            if (halted || (error != 2'd0)) done = 1'b1;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_sig(input string tag, input bit which_in);
        bit seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clock);
            if (which_in ? in_ready : out_valid) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input string p, input logic [1:0] exp_err);
        do_reset();
        load_prog(p);
        pulse_start();
        wait_done(tag);
        chk({tag, "_halted"}, {31'h0, halted}, {31'h0, (exp_err == 2'd0)});
        chk({tag, "_error"}, {30'h0, error}, {30'h0, exp_err});
        chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
        chk({tag, "_missing"}, exp_q.size(), 32'd0);
        chk({tag, "_extra"}, n_extra, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = 4'hF;
        do_reset();
        @(negedge clock);
        chk("rst_pm_addr", {16'h0, pm_addr}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_error", {30'h0, error}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);

        exp_q.push_back(8'd3);
        run("inc3", "+++.H", 2'd0);
        // start must be ignored once halted
        pulse_start();
        repeat (4) @(negedge clock);
        chk("halt_sticky", {31'h0, halted}, 32'd1);
        chk("halt_busy", {31'h0, busy}, 32'd0);

`ifdef BF_SATURATE_EN
        exp_q.push_back(8'd0);
`else
        exp_q.push_back(8'd255);
`endif
        run("dec0", "-.H", 2'd0);

        exp_q.push_back(8'd1);
        run("dpwrap", "<+.H", 2'd0);
        chk("tape255", {24'h0, u_dut.u_tape.cells_r[255]}, 32'd1);
        chk("tape0", {24'h0, u_dut.u_tape.cells_r[0]}, 32'd0);

        exp_q.push_back(8'd6);
        run("loop", "++[>+++<-]>.H", 2'd0);

        exp_q.push_back(8'd1);
        run("skipnest", "[[]]+.H", 2'd0);

        exp_q.push_back(8'd2);
        run("nop", "+N+.H", 2'd0);

        run("unm_open", "[H", 2'd1);
        run("unm_close", "+]", 2'd2);

        // Input delayed 5 cycles, output stalled 3 cycles
        do_reset();
        load_prog(",.H");
        out_ready = 1'b0;
        exp_q.push_back(8'h41);
        pulse_start();
        wait_sig("in_ready", 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("in_ready_hold", {31'h0, in_ready}, 32'd1);
        end
        in_data  = 8'h41;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        chk("in_ready_drop", {31'h0, in_ready}, 32'd0);
        wait_sig("out_valid", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("out_valid_hold", {31'h0, out_valid}, 32'd1);
            chk("out_data_hold", {24'h0, out_data}, 32'h41);
        end
        out_ready = 1'b1;
        wait_done("io");
        chk("io_halted", {31'h0, halted}, 32'd1);
        chk("io_missing", exp_q.size(), 32'd0);
        exp_q.delete();

        // Reset asserted while an output handshake is open
        do_reset();
        load_prog("+.H");
        out_ready = 1'b0;
        pulse_start();
        wait_sig("rst_mid", 1'b0);
        chk("pre_rst_out", {24'h0, out_data}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_out_valid", {31'h0, out_valid}, 32'd0);
        chk("mid_out_data", {24'h0, out_data}, 32'd0);
        chk("mid_busy", {31'h0, busy}, 32'd0);
        chk("mid_pm_addr", {16'h0, pm_addr}, 32'd0);
        chk("mid_tape0", {24'h0, u_dut.u_tape.cells_r[0]}, 32'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_idle", {31'h0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bf_core_p.md
Name: bf_core_p

Overview:
Parametrised Brainfuck execution core that replaces the hand-wired PC/DP/data/DOut/ALU/mux datapath with one self-contained sequenced block. It fetches 4-bit opcodes from an external program memory with 1-cycle read latency and holds the data tape in an internal register array. Character I/O uses valid/ready handshakes. Bracket matching is done by a nesting-counter scan, replacing BCount.

Parameters:
- DATA_W, 8, cell width in bits.
- TAPE_DEPTH, 256, number of tape cells; must be a power of 2; DP_W = clog2(TAPE_DEPTH).
- PC_W, 16, program address width.
- NEST_W, 8, bracket nesting counter width.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- start, input, 1, 1-cycle pulse; starts execution from IDLE.
- pm_addr, output, PC_W, program memory read address.
- pm_data, input, 4, opcode returned one cycle after pm_addr.
- in_data, input, DATA_W, input character.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, core is accepting input (',' pending).
- out_data, output, DATA_W, output character.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, sink accepts out_data.
- busy, output, 1, state is not IDLE, HALT or ERROR.
- halted, output, 1, a HALT opcode was executed.
- error, output, 2, error code: 0 none, 1 unmatched '[', 2 unmatched ']', 3 nesting overflow.

Behaviour:
- One clock. Reset is synchronous and active-low: when reset==0 at a rising clock edge:
  - state=IDLE, pc=0, dp=0, nest=0, every tape cell=0.
  - pm_addr=0, in_ready=0, out_valid=0, out_data=0, busy=0, halted=0, error=0.
  - This applies mid-operation in any state, including an open handshake.
- Opcodes: 0 '+', 1 '-', 2 '>', 3 '<', 4 '[', 5 ']', 6 '.', 7 ',', 4'hF HALT; 8 to 14 are NOP.
- States: IDLE, FETCH, EXEC, SCAN_F, SCAN_B, WAIT_IN, WAIT_OUT, HALT, ERROR.
- IDLE: start -> FETCH with pc=0. start is ignored in every other state.
- FETCH: pm_addr=pc; go to EXEC. EXEC decodes pm_data. A normal instruction costs 2 cycles.
- '+' and '-': tape[dp] +/- 1, modulo 2^DATA_W. pc+1, then FETCH.
- '>' and '<': dp +/- 1, modulo TAPE_DEPTH (255 + 1 -> 0; 0 - 1 -> 255). pc+1, then FETCH.
- '[':
  - tape[dp]!=0: pc+1, then FETCH.
  - tape[dp]==0: nest=1, pc+1, go to SCAN_F.
- ']':
  - tape[dp]==0: pc+1, then FETCH.
  - tape[dp]!=0: nest=1, pc-1, go to SCAN_B.
- SCAN_F and SCAN_B: 2 cycles per step (address, then decode).
  - Matching bracket type: nest+1. Opposite type: nest-1.
  - When nest reaches 0: SCAN_F sets pc = match+1; SCAN_B sets pc = match+1. Then FETCH.
  - Otherwise step pc +1 (SCAN_F) or -1 (SCAN_B).
  - SCAN_F past pc = 2^PC_W-1, or reading HALT while nest>0: ERROR, error=1.
  - SCAN_B at pc=0 without a match: ERROR, error=2.
  - nest incrementing from all-ones: ERROR, error=3.
- '.': out_data=tape[dp], out_valid=1, go to WAIT_OUT.
  - WAIT_OUT: when out_valid && out_ready, out_valid=0 on the next edge, pc+1, then FETCH.
  - out_data is held stable while out_valid=1.
- ',': in_ready=1, go to WAIT_IN.
  - WAIT_IN: when in_valid && in_ready, tape[dp]=in_data, in_ready=0, pc+1, then FETCH.
- HALT opcode: halted=1, go to HALT.
- HALT and ERROR are sticky until reset. pc and dp are frozen, busy=0.
- Increment of pc from 2^PC_W-1 in EXEC: ERROR, error=1.

Optional Feature:
- Macro BF_SATURATE_EN.
- Defined: '+' at 2^DATA_W-1 and '-' at 0 leave the cell unchanged (saturate).
- Undefined: both wrap modulo 2^DATA_W, as stated in Behaviour.

Decomposition:
- Package bf_pkg holds:
  - the opcode localparams (OP_INC .. OP_IN, OP_HALT);
  - the state enum typedef;
  - the error code constants.
- One sub-module: bf_tape.
  - DATA_W x TAPE_DEPTH register array with synchronous clear.
  - Combinational read at dp.
  - Single write port for inc/dec/load.
  - Contains the BF_SATURATE_EN arithmetic.

Test Plan:
- Program "+++.HALT", out_ready=1 -> one transfer with out_data=3, then halted=1, busy=0.
- Program "-.HALT" -> out_data=255 without BF_SATURATE_EN; out_data=0 with it.
- Program "<+.HALT" -> dp wraps to 255 and out_data=1; dump shows tape[255]=1, tape[0]=0.
- Program "++[>+++<-]>.HALT" -> out_data=6; nested "[[]]" skipped when the cell is 0 -> next opcode is executed.
- Program ",.HALT", in_data=8'h41 asserted 5 cycles late, out_ready low 3 cycles:
  - in_ready is held until the accept;
  - out_data=8'h41 is held stable until the accept.
- Program "[" then HALT -> error=1. Program "]" with cell nonzero -> error=2. reset low mid-WAIT_OUT -> all outputs 0 next cycle.
